// File: rtl/pipe_pe_pkg.sv
// Shared constants and lane helper for the pipelined vector adder.
// Optional saturation is enabled with PIPE_PE_UI_ADD_SAT_EN.
package pipe_pe_pkg;

  localparam int N_DEF     = 64;
  localparam int LANES_DEF = 1;
  localparam int DEPTH_DEF = 2;

  localparam int MAX_N = 128;
  localparam int MAX_W = 4096;

  // Lane i of width n, zero-extended to MAX_N bits.
  function automatic logic [MAX_N-1:0] lane_of(
    input logic [MAX_W-1:0] v,
    input int               i,
    input int               n
  );
    logic [MAX_N-1:0] m;
    m = (MAX_N'(1) << n) - MAX_N'(1);
    return MAX_N'(v >> (i * n)) & m;
  endfunction

endpackage

// File: rtl/pipe_pe_stage.sv
// One pipeline slot: valid bit plus data word, enabled by the
// global advance and cleared by synchronous reset.
module pipe_pe_stage
  import pipe_pe_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_pe_ui_add_vec.sv
// Multi-lane unsigned adder feeding a globally stalled pipeline.
// Define PIPE_PE_UI_ADD_SAT_EN for per-lane saturation on overflow.
module pipe_pe_ui_add_vec
  import pipe_pe_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trigger,
  output logic               cts,
  input  logic [LANES*N-1:0] in1,
  input  logic [LANES*N-1:0] in2,
  output logic [LANES*N-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   carry
);

  localparam int W = LANES * N + LANES;

  logic               adv;
  logic [LANES*N-1:0] sum_d;
  logic [LANES-1:0]   cy_d;
  logic               vld [DEPTH+1];
  logic [W-1:0]       dat [DEPTH+1];

  assign adv = ~(out_valid & ~out_ready);
  assign cts = adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [MAX_N-1:0] a_w;
    logic [MAX_N-1:0] b_w;
    logic [N:0]       s;

    assign a_w = lane_of(MAX_W'(in1), i, N);
    assign b_w = lane_of(MAX_W'(in2), i, N);
    assign s   = {1'b0, a_w[N-1:0]} + {1'b0, b_w[N-1:0]};

    if (N < MAX_N) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^{a_w[MAX_N-1:N], b_w[MAX_N-1:N]};
    end

`ifdef PIPE_PE_UI_ADD_SAT_EN
    assign sum_d[i*N +: N] = s[N] ? {N{1'b1}} : s[N-1:0];
`else
    assign sum_d[i*N +: N] = s[N-1:0];
`endif
    assign cy_d[i] = s[N];
  end

  assign vld[0] = trigger;
  assign dat[0] = {cy_d, sum_d};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_pe_stage #(
      .W(W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (adv),
      .valid_d (vld[k]),
      .data_d  (dat[k]),
      .valid_q (vld[k+1]),
      .data_q  (dat[k+1])
    );
  end

  assign out_valid    = vld[DEPTH];
  assign {carry, out} = dat[DEPTH];

endmodule

// File: tb/tb_pipe_pe_ui_add_vec.sv
// Directed bench for pipe_pe_ui_add_vec: latency, throughput,
// backpressure, wrap, mid-run reset and lane isolation.
module tb_pipe_pe_ui_add_vec;

`ifdef PIPE_PE_UI_ADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic        cts;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [15:0] out;
  logic        ov;
  logic        rdy;
  logic [1:0]  carry;

  logic        trig_b;
  logic        cts_b;
  logic [31:0] a_b;
  logic [31:0] b_b;
  logic [31:0] out_b;
  logic        ov_b;
  logic [3:0]  carry_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_pe_ui_add_vec #(
    .N(8), .LANES(2), .DEPTH(3)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trig),
    .cts       (cts),
    .in1       (a_in),
    .in2       (b_in),
    .out       (out),
    .out_valid (ov),
    .out_ready (rdy),
    .carry     (carry)
  );

  pipe_pe_ui_add_vec #(
    .N(8), .LANES(4), .DEPTH(3)
  ) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trig_b),
    .cts       (cts_b),
    .in1       (a_b),
    .in2       (b_b),
    .out       (out_b),
    .out_valid (ov_b),
    .out_ready (1'b1),
    .carry     (carry_b)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] exp2(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [8:0]  s;
    logic [17:0] r;
    r = '0;
    for (int l = 0; l < 2; l++) begin
      s = {1'b0, a[l*8 +: 8]} + {1'b0, b[l*8 +: 8]};
      r[l*8 +: 8] = (SAT && s[8]) ? 8'hFF : s[7:0];
      r[16+l] = s[8];
    end
    return r;
  endfunction

  function automatic logic [15:0] mk_a(input int i);
    return {8'(i + 1), 8'(i * 3)};
  endfunction

  function automatic logic [15:0] mk_b(input int i);
    return {8'(i), 8'(100 + i * 7)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams n items; out_ready low for stn cycles starting at st0.
  task automatic run_stream(input int n, input int st0, input int stn);
    logic [17:0] q[$];
    int          sent;
    int          got;
    int          cyc;
    bit          gap;
    bit          stall;
    logic [15:0] held;
    sent = 0;
    got  = 0;
    cyc  = 0;
    gap  = 1'b0;
    held = '0;
    while (got < n && cyc < 200) begin
      stall = (cyc >= st0) && (cyc < st0 + stn);
      rdy   = ~stall;
      trig  = (sent < n);
      a_in  = mk_a(sent);
      b_in  = mk_b(sent);
      #1;
      if (stall && ov) begin
        check("bp_cts", 64'(cts), 64'd0);
        if (cyc > st0) check("bp_hold", 64'(out), 64'(held));
      end
      if (stn == 0 && got > 0 && !ov) gap = 1'b1;
      if (ov && rdy) begin
        if (q.size() == 0) begin
          check("dup", 64'd1, 64'd0);
        end else begin
          check("order", 64'({carry, out}), 64'(q.pop_front()));
        end
        got++;
      end
      if (trig && cts) begin
        q.push_back(exp2(a_in, b_in));
        sent++;
      end
      held = out;
      tick();
      cyc++;
    end
    trig = 1'b0;
    rdy  = 1'b1;
    check("stream_count", 64'(got), 64'(n));
    check("stream_sent", 64'(sent), 64'(n));
    if (stn == 0) check("no_gap", 64'(gap), 64'd0);
    repeat (4) tick();
    check("drain_idle", 64'(ov), 64'd0);
  endtask

  initial begin
    bit seen;
    rst    = 1'b1;
    trig   = 1'b0;
    rdy    = 1'b1;
    a_in   = '0;
    b_in   = '0;
    trig_b = 1'b0;
    a_b    = '0;
    b_b    = '0;

    repeat (2) tick();
    check("rst_valid", 64'(ov), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_cts", 64'(cts), 64'd1);

    rst  = 1'b0;
    trig = 1'b1;
    a_in = {8'd10, 8'd200};
    b_in = {8'd5, 8'd100};
    tick();
    trig = 1'b0;
    check("lat_k0", 64'(ov), 64'd0);
    tick();
    check("lat_k1", 64'(ov), 64'd0);
    tick();
    check("lat_valid", 64'(ov), 64'd1);
    check("lat_out", 64'(out), SAT ? 64'h0FFF : 64'h0F2C);
    check("lat_carry", 64'(carry), 64'b01);
    tick();
    check("lat_consumed", 64'(ov), 64'd0);

    trig = 1'b1;
    a_in = 16'hFFFF;
    b_in = 16'hFFFF;
    tick();
    trig = 1'b0;
    repeat (2) tick();
    check("wrap_valid", 64'(ov), 64'd1);
    check("wrap_out", 64'(out), SAT ? 64'hFFFF : 64'hFEFE);
    check("wrap_carry", 64'(carry), 64'b11);
    repeat (2) tick();

    run_stream(20, 1000, 0);
    run_stream(12, 5, 5);

    trig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in = mk_a(i);
      b_in = mk_b(i);
      tick();
    end
    trig = 1'b0;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 64'(ov), 64'd0);
    check("mrst_out", 64'(out), 64'd0);
    check("mrst_carry", 64'(carry), 64'd0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (ov) seen = 1'b1;
    end
    check("mrst_quiet", 64'(seen), 64'd0);

    trig_b = 1'b1;
    a_b    = 32'h11_22_F0_33;
    b_b    = 32'h01_02_20_04;
    tick();
    trig_b = 1'b0;
    repeat (2) tick();
    check("iso1_valid", 64'(ov_b), 64'd1);
    check("iso1_out", 64'(out_b), SAT ? 64'h1224FF37 : 64'h12241037);
    check("iso1_carry", 64'(carry_b), 64'b0010);

    trig_b = 1'b1;
    a_b    = 32'h0000_00FF;
    b_b    = 32'h0000_0001;
    tick();
    trig_b = 1'b0;
    repeat (2) tick();
    check("iso0_out", 64'(out_b), SAT ? 64'h000000FF : 64'h00000000);
    check("iso0_carry", 64'(carry_b), 64'b0001);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
